block_dispatcher: RTL

//  Top-level scheduler for the block-matrix coprocessor. On i_Start it walks every output block
//  C_ij (i,j in 0..mu-1, row-major) and hands each (i,j) to a free compute CU via the CU index

---
 rtl/block_dispatcher.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/block_dispatcher.sv
// Block-matrix scheduler: walks every output block C_ij in row-major order, hands each one to the
// lowest free compute CU, and counts CU write-backs until all mu*mu blocks are complete.
//   state      | meaning
//   S_IDLE     | waiting for i_Start
//   S_DISPATCH | handing out (i,j) pairs, at most one per cycle
//   S_DRAIN    | all pairs issued, waiting for outstanding results
//   S_DONE     | one-cycle o_Done, then back to idle
module block_dispatcher #(
  parameter int NUM_CU      = 4,
  parameter int index_width = 8,
  parameter int max_mu_log  = 8
) (
  input  logic                            i_Clock,
  input  logic                            i_Reset,
  input  logic                            i_Start,
  input  logic [max_mu_log-1:0]           i_mu,
  output logic [max_mu_log-1:0]           o_mu,
  output logic [NUM_CU*index_width-1:0]   o_Row_Index,
  output logic [NUM_CU*index_width-1:0]   o_Column_Index,
  output logic [NUM_CU-1:0]               o_Indexes_Ready,
  input  logic [NUM_CU-1:0]               i_Result_Ready,
  output logic                            o_Busy,
  output logic                            o_Done,
  output logic [2*max_mu_log-1:0]         o_Blocks_Done
);

  localparam int CW = 2 * max_mu_log;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

  state_t                  state, next_state;
  logic [NUM_CU-1:0]       r_Result_Prev;
  logic [NUM_CU-1:0]       comp;
  logic [NUM_CU-1:0]       cu_busy;
  logic [NUM_CU-1:0]       dispatch;
  logic                    any_dispatch;
  logic [max_mu_log-1:0]   row_cnt, col_cnt, mu_m1;
  logic                    last_block;
  logic                    zero_done;
  logic                    start_ok;
  logic [CW-1:0]           comp_count, blocks_next, total_blocks;
  logic [index_width-1:0]  row_hold [NUM_CU];
  logic [index_width-1:0]  col_hold [NUM_CU];

  assign comp         = i_Result_Ready & ~r_Result_Prev;
  assign mu_m1        = o_mu - max_mu_log'(1);
  assign last_block   = (row_cnt == mu_m1) && (col_cnt == mu_m1);
  assign total_blocks = CW'(o_mu) * CW'(o_mu);
  assign blocks_next  = o_Blocks_Done + comp_count;
  assign any_dispatch = |dispatch;
  assign start_ok     = (state == S_IDLE) && i_Start && (i_mu != '0);

  always_comb begin
    comp_count = '0;
    for (int c = 0; c < NUM_CU; c++)
      comp_count = comp_count + CW'(comp[c]);
  end

  // descending scan so the lowest-numbered free CU wins
  always_comb begin
    dispatch = '0;
    if (state == S_DISPATCH) begin
      for (int c = NUM_CU - 1; c >= 0; c--) begin
        if (!cu_busy[c] && !comp[c]) begin
          dispatch    = '0;
          dispatch[c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start_ok) next_state = S_DISPATCH;
      S_DISPATCH: if (any_dispatch && last_block) next_state = S_DRAIN;
      S_DRAIN:    if (blocks_next == total_blocks) next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  assign o_Indexes_Ready = dispatch;
  assign o_Busy          = (state == S_DISPATCH) || (state == S_DRAIN);
  assign o_Done          = (state == S_DONE) || zero_done;

  for (genvar c = 0; c < NUM_CU; c++) begin : g_slice
    assign o_Row_Index[c*index_width +: index_width]    = dispatch[c] ? index_width'(row_cnt) : row_hold[c];
    assign o_Column_Index[c*index_width +: index_width] = dispatch[c] ? index_width'(col_cnt) : col_hold[c];
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= S_IDLE;
      r_Result_Prev <= '0;
      cu_busy       <= '0;
      zero_done     <= 1'b0;
      o_mu          <= '0;
      o_Blocks_Done <= '0;
      row_cnt       <= '0;
      col_cnt       <= '0;
      for (int c = 0; c < NUM_CU; c++) begin
        row_hold[c] <= '0;
        col_hold[c] <= '0;
      end
    end else begin
      state         <= next_state;
      r_Result_Prev <= i_Result_Ready;
      cu_busy       <= (cu_busy & ~comp) | dispatch;
      zero_done     <= (state == S_IDLE) && i_Start && (i_mu == '0);
      if (state == S_IDLE) begin
        if (start_ok) begin
          o_mu          <= i_mu;
          row_cnt       <= '0;
          col_cnt       <= '0;
          o_Blocks_Done <= '0;
        end
      end else begin
        o_Blocks_Done <= blocks_next;
      end
      if (any_dispatch) begin
        if (col_cnt != mu_m1) begin
          col_cnt <= col_cnt + max_mu_log'(1);
        end else begin
          col_cnt <= '0;
          row_cnt <= row_cnt + max_mu_log'(1);
        end
      end
      for (int c = 0; c < NUM_CU; c++) begin
        if (dispatch[c]) begin
          row_hold[c] <= index_width'(row_cnt);
          col_hold[c] <= index_width'(col_cnt);
        end
      end
    end
  end

`ifndef SYNTHESIS
  // results landing in idle (e.g. left over from an abandoned job) are expected and ignored
  always_ff @(posedge i_Clock) begin
    if (!i_Reset && state != S_IDLE)
      a1_spurious: assert ((comp & ~cu_busy) == '0)
        else $error("spurious CU result: comp=%b cu_busy=%b", comp, cu_busy);
  end
`endif

endmodule
